// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the MEM stage (P) gets a zero-latency pass-through, while the debug/loader
// port (D) takes idle cycles or is forced in after STARVE_LIMIT consecutive denied cycles.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_p_re,
    input  logic        i_p_we,
    input  logic [63:0] i_p_addr,
    input  logic [63:0] i_p_wdata,
    output logic [63:0] o_p_rdata,
    output logic        o_p_stall,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [63:0] i_d_addr,
    input  logic [63:0] i_d_wdata,
    output logic [63:0] o_d_rdata,
    output logic        o_d_ack,
    output logic        o_mem_write,
    output logic        o_mem_read,
    output logic [63:0] o_mem_addr,
    output logic [63:0] o_write_data,
    input  logic [63:0] i_data_out
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [63:0]     r_d_rdata;
    logic            w_p_act;
    logic            w_d_serve;
    logic            w_mem_we;

    assign w_p_act = i_p_re | i_p_we;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_d_serve && !i_d_we) begin
                r_d_rdata <= i_data_out;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle: begin
                if (i_d_req) begin
                    if (w_d_serve) begin
                        w_state_nxt = StAck;
                    end else begin
                        w_cnt_nxt   = CntOne;
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                if (!i_d_req) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StIdle;
                end else if (w_d_serve) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StAck;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end
            StAck: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        w_d_serve    = 1'b0;
        w_mem_we     = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_addr   = '0;
        o_write_data = '0;
        o_p_rdata    = '0;
        case (r_state)
            StIdle:  w_d_serve = i_d_req & ~w_p_act;
            StWait:  w_d_serve = i_d_req & (~w_p_act | (r_cnt == CntMax));
            default: w_d_serve = 1'b0;
        endcase
        if (w_d_serve) begin
            w_mem_we     = i_d_we;
            o_mem_read   = ~i_d_we;
            o_mem_addr   = i_d_addr;
            o_write_data = i_d_wdata;
        end else if (w_p_act) begin
            w_mem_we     = i_p_we;
            o_mem_read   = i_p_re;
            o_mem_addr   = i_p_addr;
            o_write_data = i_p_wdata;
            if (i_p_re) begin
                o_p_rdata = i_data_out;
            end
        end
        // No write may reach the array while reset is held, even if inputs are active.
        o_mem_write = w_mem_we & ~i_reset;
        o_p_stall   = w_p_act & w_d_serve;
        o_d_ack     = (r_state == StAck);
        o_d_rdata   = r_d_rdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a cycle-level reference model of the
// arbitration rules and a small behavioural memory on the MEM_* pins.
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        p_re, p_we, d_req, d_we;
    logic [63:0] p_addr, p_wdata, d_addr, d_wdata;
    logic [63:0] p_rdata, d_rdata, mem_addr, write_data, data_out;
    logic        p_stall, d_ack, mem_write, mem_read;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_p_re      (p_re),
        .i_p_we      (p_we),
        .i_p_addr    (p_addr),
        .i_p_wdata   (p_wdata),
        .o_p_rdata   (p_rdata),
        .o_p_stall   (p_stall),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_rdata   (d_rdata),
        .o_d_ack     (d_ack),
        .o_mem_write (mem_write),
        .o_mem_read  (mem_read),
        .o_mem_addr  (mem_addr),
        .o_write_data(write_data),
        .i_data_out  (data_out)
    );

    // Data memory attached to the arbiter (16 words, indexed by low address bits).
    logic [63:0] dmem [16];
    assign data_out = dmem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr[3:0]] <= write_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          rst;
        logic        we;
        logic        re;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] prdata;
        logic        stall;
    } exp_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } dresp_t;

    exp_t   q_exp[$];
    dresp_t q_d[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;

    // Reference model state: memory image, denied-cycle count of the pending D request,
    // whether D was served last cycle (turnaround), and the last D read value.
    logic [63:0] ref_mem [16];
    int          m_denied = 0;
    bit          m_turn   = 0;
    logic [63:0] m_last   = '0;

    task automatic chk(input string name, input int c, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, act, exp);
        end
    endtask

    task automatic drive(input bit r, input logic pre, input logic pwe, input logic [63:0] pa,
                         input logic [63:0] pw, input logic dq, input logic dw,
                         input logic [63:0] da, input logic [63:0] dwd);
        exp_t   e;
        dresp_t rsp;
        bit     act, serve, was_turn;
        @(posedge clk);
        #1;
        rst = r; p_re = pre; p_we = pwe; p_addr = pa; p_wdata = pw;
        d_req = dq; d_we = dw; d_addr = da; d_wdata = dwd;
        e = '{cyc: cyc, rst: r, we: 1'b0, re: 1'b0, addr: '0, wdata: '0, prdata: '0,
              stall: 1'b0};
        if (r) begin
            m_denied = 0;
            m_turn   = 0;
            m_last   = '0;
            if (q_d.size() > 0 && q_d[q_d.size()-1].due >= cyc) q_d.delete(q_d.size() - 1);
        end else begin
            act      = pre | pwe;
            was_turn = m_turn;
            serve    = dq && !was_turn && (!act || m_denied == int'(LIMIT));
            if (serve) begin
                e.we = dw; e.re = !dw; e.addr = da; e.wdata = dwd;
            end else if (act) begin
                e.we = pwe; e.re = pre; e.addr = pa; e.wdata = pw;
                if (pre) e.prdata = ref_mem[pa[3:0]];
            end
            e.stall  = act && serve;
            m_denied = (dq && !was_turn && !serve) ? m_denied + 1 : 0;
            m_turn   = serve;
            if (serve) begin
                if (dw) ref_mem[da[3:0]] = dwd;
                else m_last = ref_mem[da[3:0]];
                rsp = '{due: cyc + 1, data: m_last};
                q_d.push_back(rsp);
            end else if (act && pwe) begin
                ref_mem[pa[3:0]] = pw;
            end
        end
        q_exp.push_back(e);
        cyc++;
    endtask

    // Monitor: compares every cycle's outputs and every D_ACK against the scoreboard.
    initial begin
        exp_t   e;
        dresp_t rsp;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                if (e.rst) begin
                    chk("rst_mem_write", e.cyc, 64'(mem_write), 64'(0));
                    chk("rst_d_rdata", e.cyc, d_rdata, 64'(0));
                end else begin
                    chk("mem_write", e.cyc, 64'(mem_write), 64'(e.we));
                    chk("mem_read", e.cyc, 64'(mem_read), 64'(e.re));
                    chk("mem_addr", e.cyc, mem_addr, e.addr);
                    chk("write_data", e.cyc, write_data, e.wdata);
                    chk("p_rdata", e.cyc, p_rdata, e.prdata);
                    chk("p_stall", e.cyc, 64'(p_stall), 64'(e.stall));
                end
                if (q_d.size() > 0 && q_d[0].due == e.cyc) begin
                    rsp = q_d.pop_front();
                    chk("d_ack", e.cyc, 64'(d_ack), 64'(1));
                    if (!e.rst) chk("d_rdata", e.cyc, d_rdata, rsp.data);
                end else begin
                    chk("d_ack_idle", e.cyc, 64'(d_ack), 64'(0));
                end
            end
        end
    end

    logic        tx_req, tx_we, tx_done;
    logic [63:0] tx_addr, tx_wdata;

    task automatic new_tx();
        tx_req   = 1'b1;
        tx_we    = 1'($urandom_range(0, 1));
        tx_addr  = {$urandom(), $urandom()};
        tx_wdata = {$urandom(), $urandom()};
    endtask

    initial begin
        int          busy;
        logic        pre, pwe;
        logic [63:0] pa, pw;
        for (int i = 0; i < 16; i++) begin
            dmem[i]    = 64'h0101_0101_0101_0101 * 64'(i);
            ref_mem[i] = 64'h0101_0101_0101_0101 * 64'(i);
        end
        rst = 1'b1; p_re = 0; p_we = 0; d_req = 0; d_we = 0;
        p_addr = '0; p_wdata = '0; d_addr = '0; d_wdata = '0;

        // Reset with active D write and P write requests.
        drive(1, 0, 1, 64'd5, 64'hDEAD, 1, 1, 64'd6, 64'hBEEF);
        drive(1, 0, 1, 64'd5, 64'hDEAD, 1, 1, 64'd6, 64'hBEEF);
        // Seed mem[1] = 0xC4, then idle D read of address 1.
        drive(0, 0, 1, 64'd1, 64'hC4, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 64'd1, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 64'd1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Starvation: P reads continuously, D write forced in after LIMIT denied cycles.
        for (int i = 0; i < int'(LIMIT) + 2; i++) drive(0, 1, 0, 64'd7, 0, 1, 1, 64'd0, 64'h55);
        drive(0, 1, 0, 64'd0, 0, 0, 0, 0, 0);
        // Simultaneous P write and D read: P wins, D served next cycle.
        drive(0, 0, 1, 64'd2, 64'hAA, 1, 0, 64'd3, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 64'd3, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 64'd3, 0);
        // Abort while starved, then restart the request.
        drive(0, 1, 0, 64'd9, 0, 1, 0, 64'd8, 0);
        drive(0, 1, 0, 64'd9, 0, 1, 0, 64'd8, 0);
        drive(0, 1, 0, 64'd9, 0, 0, 0, 64'd8, 0);
        for (int i = 0; i < int'(LIMIT) + 2; i++) drive(0, 1, 0, 64'd9, 0, 1, 0, 64'd8, 0);
        // Back-to-back D reads with P idle.
        drive(0, 0, 0, 0, 0, 1, 0, 64'd4, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 64'd5, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 64'd5, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 64'd5, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic at several P load levels, with occasional resets.
        tx_req = 0; tx_we = 0; tx_done = 0; tx_addr = '0; tx_wdata = '0;
        for (int i = 0; i < 3000; i++) begin
            case (i / 600)
                0:       busy = 0;
                1:       busy = 50;
                2:       busy = 90;
                3:       busy = 100;
                default: busy = 70;
            endcase
            if (tx_done) begin
                tx_req  = 0;
                tx_done = 0;
                if ($urandom_range(0, 2) == 0) new_tx();
            end else if (m_turn) begin
                if ($urandom_range(0, 1) == 1) new_tx();
                else tx_done = 1;
            end else if (tx_req) begin
                if ($urandom_range(0, 19) == 0) tx_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                new_tx();
            end
            pre = 0; pwe = 0;
            if (int'($urandom_range(0, 99)) < busy) begin
                if ($urandom_range(0, 1) == 1) pre = 1;
                else pwe = 1;
            end
            pa = {$urandom(), $urandom()};
            pw = {$urandom(), $urandom()};
            if ($urandom_range(0, 399) == 0) begin
                drive(1, pre, pwe, pa, pw, tx_req, tx_we, tx_addr, tx_wdata);
                tx_done = 0;
            end else begin
                drive(0, pre, pwe, pa, pw, tx_req, tx_we, tx_addr, tx_wdata);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("d_resp_drain", cyc, 64'(q_d.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
